// File: rtl/perf_counter_unit.sv
// perf_counter_unit
//   Performance-monitor block. Counts cycles, retired instructions and NUM_EV
//   generic event lines. On snap_req it freezes a coherent snapshot of every
//   counter into shadow registers and streams it out one counter per beat
//   over a valid/ready interface.
//
//   Counter index map (shared by rd_idx and ovf):
//     0      cycles  (every clock with en)
//     1      instrs  (en && retire)
//     2 + i  event i (en && ev_in[i])
//
//   Build option: define PERF_SAT_EN to make counters saturate at all-ones
//   instead of wrapping to zero. ovf is set on the first increment past the
//   maximum in either build.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous reset, active low
//   en        in   global count enable
//   retire    in   one instruction retired this cycle
//   ev_in     in   per-event increment strobes [NUM_EV]
//   clear     in   zero live counters and ovf (shadow and stream untouched)
//   snap_req  in   capture snapshot and start readout (ignored while busy)
//   busy      out  snapshot stream in progress
//   rd_valid  out  beat valid
//   rd_ready  in   consumer ready
//   rd_idx    out  counter index of current beat [IDX_W]
//   rd_data   out  snapshot value of current beat [CNT_W]
//   rd_last   out  current beat is index NUM_EV+1
//   ovf       out  sticky overflow flags [NUM_EV+2]
module perf_counter_unit #(
  parameter int CNT_W  = 32,
  parameter int NUM_EV = 4,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              retire,
  input  logic [NUM_EV-1:0] ev_in,
  input  logic              clear,
  input  logic              snap_req,
  output logic              busy,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [IDX_W-1:0]  rd_idx,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_last,
  output logic [NUM_EV+1:0] ovf
);

  localparam int NCNT = NUM_EV + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCNT - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] live_q   [NCNT];
  logic [CNT_W-1:0] live_d   [NCNT];
  logic [CNT_W-1:0] shadow_q [NCNT];
  logic [NCNT-1:0]  ovf_q;
  logic [NCNT-1:0]  ovf_d;
  logic [NCNT-1:0]  inc;
  logic [IDX_W-1:0] rd_idx_q;
  logic             rd_valid_q;
  logic             busy_q;
  logic             rd_last_q;
  logic [CNT_W-1:0] rd_data_c;

  assign inc = {ev_in & {NUM_EV{en}}, en & retire, en};

  // clear has priority over any increment in the same cycle.
  always_comb begin
    live_d = live_q;
    ovf_d  = ovf_q;
    for (int k = 0; k < NCNT; k++) begin
      if (clear) begin
        live_d[k] = '0;
        ovf_d[k]  = 1'b0;
      end else if (inc[k]) begin
        if (&live_q[k]) begin
          ovf_d[k] = 1'b1;
`ifdef PERF_SAT_EN
          live_d[k] = live_q[k];
`else
          live_d[k] = '0;
`endif
        end else begin
          live_d[k] = live_q[k] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NCNT; k++) live_q[k] <= '0;
      ovf_q <= '0;
    end else begin
      live_q <= live_d;
      ovf_q  <= ovf_d;
    end
  end

  // Shadow is loaded from live_q, i.e. the value before this edge's
  // increment or clear, so a snapshot taken together with clear still
  // sees the pre-clear counts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      rd_idx_q   <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      rd_last_q  <= 1'b0;
      for (int k = 0; k < NCNT; k++) shadow_q[k] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (snap_req) begin
            shadow_q   <= live_q;
            state_q    <= S_STREAM;
            rd_idx_q   <= '0;
            rd_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            rd_last_q  <= 1'b0;
          end
        end
        S_STREAM: begin
          if (rd_ready) begin
            if (rd_last_q) begin
              state_q    <= S_IDLE;
              rd_idx_q   <= '0;
              rd_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              rd_last_q  <= 1'b0;
            end else begin
              rd_idx_q  <= rd_idx_q + IDX_W'(1);
              rd_last_q <= (rd_idx_q + IDX_W'(1)) == LAST_IDX;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data_c = '0;
    for (int k = 0; k < NCNT; k++) begin
      if (rd_idx_q == IDX_W'(k)) rd_data_c = shadow_q[k];
    end
  end

  assign busy     = busy_q;
  assign rd_valid = rd_valid_q;
  assign rd_idx   = rd_idx_q;
  assign rd_data  = rd_data_c;
  assign rd_last  = rd_last_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_perf_counter_unit.sv
module tb_perf_counter_unit;

  localparam int CNT_W  = 8;
  localparam int NUM_EV = 4;
  localparam int IDX_W  = 5;
`ifdef PERF_SAT_EN
  localparam int WRAP_EXP = 255;
`else
  localparam int WRAP_EXP = 4;
`endif

  logic              clk;
  logic              rst;
  logic              en;
  logic              retire;
  logic [NUM_EV-1:0] ev_in;
  logic              clear;
  logic              snap_req;
  logic              busy;
  logic              rd_valid;
  logic              rd_ready;
  logic [IDX_W-1:0]  rd_idx;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_last;
  logic [NUM_EV+1:0] ovf;

  typedef struct {
    int idx;
    int data;
    int last;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  beat_t hold_q[$];

  int total = 0;
  int bad   = 0;

  perf_counter_unit #(.CNT_W(CNT_W), .NUM_EV(NUM_EV), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .en(en), .retire(retire), .ev_in(ev_in),
    .clear(clear), .snap_req(snap_req), .busy(busy), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_idx(rd_idx), .rd_data(rd_data),
    .rd_last(rd_last), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; retire = 1'b0; ev_in = '0;
    clear = 1'b0; snap_req = 1'b0; rd_ready = 1'b1;
    tick();
    rst = 1'b1;
  endtask

  task automatic push_snap(input int v0, input int v1, input int v2,
                           input int v3, input int v4, input int v5);
    int v[6];
    v = '{v0, v1, v2, v3, v4, v5};
    for (int k = 0; k < 6; k++) exp_q.push_back('{k, v[k], (k == 5) ? 1 : 0});
  endtask

  task automatic snap();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
  endtask

  // Monitor: records each transfer (valid && ready at the coming edge) and
  // every stalled cycle, until the stream ends or the budget runs out.
  task automatic collect(input int stall_at, input int stall_n,
                         input int snap_at, output bit to);
    int stalled = 0;
    beat_t b;
    for (int c = 0; c < 60 && rd_valid; c++) begin
      snap_req = (snap_at >= 0 && int'(rd_idx) == snap_at);
      b = '{int'(rd_idx), int'(rd_data), int'(rd_last)};
      if (int'(rd_idx) == stall_at && stalled < stall_n) begin
        rd_ready = 1'b0;
        stalled++;
        hold_q.push_back(b);
      end else begin
        rd_ready = 1'b1;
        obs_q.push_back(b);
      end
      tick();
    end
    snap_req = 1'b0;
    rd_ready = 1'b1;
    to = rd_valid;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rd_valid); end
    total++; if (rd_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", rd_last); end
    total++; if (rd_idx !== '0) begin bad++; $display("FAIL reset_idx: got %0d want 0", rd_idx); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_data: got %0d want 0", rd_data); end
    total++; if (ovf !== '0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_basic();
    bit to;
    beat_t e, o;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      retire = (i % 2 == 0);
      tick();
    end
    en = 1'b0; retire = 1'b0;
    push_snap(10, 5, 0, 0, 0, 0);
    snap();
    total++; if (busy !== 1'b1 || rd_valid !== 1'b1 || rd_idx !== '0) begin
      bad++; $display("FAIL basic_first_beat: got busy=%b valid=%b idx=%0d want 1 1 0", busy, rd_valid, rd_idx);
    end
    collect(-1, 0, -1, to);
    total++; if (to) begin bad++; $display("FAIL basic_timeout: stream still valid, want ended"); end
    total++; if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL basic_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o.idx != e.idx || o.data != e.data || o.last != e.last) begin
        bad++; $display("FAIL basic_beat: got idx=%0d data=%0d last=%0d want idx=%0d data=%0d last=%0d", o.idx, o.data, o.last, e.idx, e.data, e.last);
      end
    end
    exp_q.delete(); obs_q.delete();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_stall();
    bit to;
    beat_t e, o;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      retire = (i < 6);
      ev_in  = {1'(i < 1), 1'(i < 2), 1'(i < 3), 1'(i < 4)};
      tick();
    end
    // Keep counting through the stream; the snapshot must not move.
    retire = 1'b1; ev_in = '1;
    push_snap(8, 6, 4, 3, 2, 1);
    snap();
    collect(2, 3, -1, to);
    en = 1'b0; retire = 1'b0; ev_in = '0;
    total++; if (to) begin bad++; $display("FAIL stall_timeout: stream still valid, want ended"); end
    total++; if (hold_q.size() != 3) begin bad++; $display("FAIL stall_cycles: got %0d want 3", hold_q.size()); end
    while (hold_q.size() > 0) begin
      o = hold_q.pop_front();
      total++; if (o.idx != 2 || o.data != 4) begin
        bad++; $display("FAIL stall_hold: got idx=%0d data=%0d want idx=2 data=4", o.idx, o.data);
      end
    end
    total++; if (obs_q.size() != 6) begin bad++; $display("FAIL stall_count: got %0d beats want 6", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o.idx != e.idx || o.data != e.data || o.last != e.last) begin
        bad++; $display("FAIL stall_beat: got idx=%0d data=%0d last=%0d want idx=%0d data=%0d last=%0d", o.idx, o.data, o.last, e.idx, e.data, e.last);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_overflow();
    bit to;
    beat_t e, o;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 260; i++) tick();
    en = 1'b0;
    total++; if (ovf !== 6'b000001) begin bad++; $display("FAIL ovf_flags: got %b want 000001", ovf); end
    push_snap(WRAP_EXP, 0, 0, 0, 0, 0);
    snap();
    collect(-1, 0, -1, to);
    total++; if (to) begin bad++; $display("FAIL ovf_timeout: stream still valid, want ended"); end
    total++; if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL ovf_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o.idx != e.idx || o.data != e.data || o.last != e.last) begin
        bad++; $display("FAIL ovf_beat: got idx=%0d data=%0d last=%0d want idx=%0d data=%0d last=%0d", o.idx, o.data, o.last, e.idx, e.data, e.last);
      end
    end
    exp_q.delete(); obs_q.delete();
    total++; if (ovf[0] !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", ovf[0]); end
  endtask

  // Starts from the overflowed state left by test_overflow, so clearing
  // ovf is a real change.
  task automatic test_clear();
    bit to;
    beat_t e, o;
    en = 1'b1; ev_in = 4'b0001;
    for (int i = 0; i < 7; i++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0; en = 1'b0; ev_in = '0;
    total++; if (ovf !== '0) begin bad++; $display("FAIL clear_ovf: got %b want 0", ovf); end
    push_snap(0, 0, 0, 0, 0, 0);
    snap();
    collect(-1, 0, -1, to);

    do_reset();
    en = 1'b1; ev_in = 4'b0001;
    for (int i = 0; i < 7; i++) tick();
    en = 1'b0; ev_in = '0;
    push_snap(7, 0, 7, 0, 0, 0);
    clear = 1'b1;
    snap();
    clear = 1'b0;
    collect(-1, 0, -1, to);
    push_snap(0, 0, 0, 0, 0, 0);
    snap();
    collect(-1, 0, -1, to);
    total++; if (to) begin bad++; $display("FAIL clear_timeout: stream still valid, want ended"); end
    total++; if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL clear_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o.idx != e.idx || o.data != e.data || o.last != e.last) begin
        bad++; $display("FAIL clear_beat: got idx=%0d data=%0d last=%0d want idx=%0d data=%0d last=%0d", o.idx, o.data, o.last, e.idx, e.data, e.last);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    bit to;
    beat_t e, o;
    do_reset();
    en = 1'b1; retire = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    en = 1'b0; retire = 1'b0;
    push_snap(4, 4, 0, 0, 0, 0);
    snap();
    collect(-1, 0, 3, to);
    total++; if (to) begin bad++; $display("FAIL b2b_timeout: stream still valid, want ended"); end
    total++; if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL b2b_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o.idx != e.idx || o.data != e.data || o.last != e.last) begin
        bad++; $display("FAIL b2b_beat: got idx=%0d data=%0d last=%0d want idx=%0d data=%0d last=%0d", o.idx, o.data, o.last, e.idx, e.data, e.last);
      end
    end
    exp_q.delete(); obs_q.delete();
    tick();
    total++; if (busy !== 1'b0 || rd_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_no_restart: got busy=%b valid=%b want 0 0", busy, rd_valid);
    end

    // Second stream, aborted by reset at idx2.
    en = 1'b1; ev_in = 4'b1010;
    snap();
    tick(); tick();
    total++; if (rd_valid !== 1'b1 || rd_idx !== 5'd2) begin
      bad++; $display("FAIL abort_pre: got valid=%b idx=%0d want 1 2", rd_valid, rd_idx);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1; en = 1'b0; ev_in = '0;
    total++; if (rd_valid !== 1'b0 || busy !== 1'b0 || rd_last !== 1'b0) begin
      bad++; $display("FAIL abort_flags: got valid=%b busy=%b last=%b want 0 0 0", rd_valid, busy, rd_last);
    end
    total++; if (rd_idx !== '0 || rd_data !== '0 || ovf !== '0) begin
      bad++; $display("FAIL abort_data: got idx=%0d data=%0d ovf=%b want 0 0 0", rd_idx, rd_data, ovf);
    end
    push_snap(0, 0, 0, 0, 0, 0);
    snap();
    collect(-1, 0, -1, to);
    total++; if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL abort_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o.idx != e.idx || o.data != e.data || o.last != e.last) begin
        bad++; $display("FAIL abort_beat: got idx=%0d data=%0d last=%0d want idx=%0d data=%0d last=%0d", o.idx, o.data, o.last, e.idx, e.data, e.last);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; retire = 1'b0; ev_in = '0;
    clear = 1'b0; snap_req = 1'b0; rd_ready = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_clear();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
